// File: rtl/masked_sbox_seq_if.sv
// Handshake bundle between the share producer/consumer and the masked S-box
// sequencer: seed load, flush, input shares and output shares.
interface masked_sbox_seq_if #(
  parameter int LFSR_W = 72
);
  logic              seed_valid;
  logic              seed_ready;
  logic [LFSR_W-1:0] seed;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;

  // Environment side: producer of shares/seed and consumer of results.
  modport master (
    output seed_valid, seed, flush, in_valid, out_ready,
    input  seed_ready, in_ready, out_valid
  );

  // Sequencer side.
  modport slave (
    input  seed_valid, seed, flush, in_valid, out_ready,
    output seed_ready, in_ready, out_valid
  );
endinterface

// File: rtl/masked_sbox_seq.sv
// Sequencer for the 6-stage, 3-share masked PRINCE S-box pipeline.
// Tracks one valid token per stage, drives the per-stage register enables
// and supplies fresh randomness from a seeded 72-bit Fibonacci LFSR that
// steps whenever the pipeline advances.
module masked_sbox_seq #(
  parameter int STAGES = 6,
  parameter int RND_W  = 12,
  parameter int LFSR_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  masked_sbox_seq_if.slave    bus,
  output logic [STAGES-1:0]   stage_en,
  output logic [LFSR_W-1:0]   rnd_out,
  output logic [2:0]          occupancy,
  output logic [CNT_W-1:0]    op_count,
  output logic                seeded
);

  // The PRNG state is sliced evenly across the stages.
  if (STAGES * RND_W != LFSR_W) begin : g_width_check
    $error("LFSR_W must equal STAGES*RND_W");
  end

  typedef enum logic {UNSEEDED, RUN} state_t;

  state_t            state;
  logic [STAGES-1:0] vld_p;
  logic [LFSR_W-1:0] lfsr_p;

  logic advance;
  logic seed_rdy;
  logic seed_load;
  logic accept;
  logic xfer;

  function automatic logic [2:0] popcount(input logic [STAGES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // Taps 72/66/25/19 (1-based) of the maximal-length polynomial.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-7] ^ s[24] ^ s[18]};
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

  // Handshake and enable decode from the registered state.
  always_comb begin
    seeded    = (state == RUN);
    advance   = !vld_p[STAGES-1] || bus.out_ready;
    occupancy = popcount(vld_p);
    seed_rdy  = (state == UNSEEDED) || ((occupancy == 3'd0) && !bus.flush);
    seed_load = bus.seed_valid && seed_rdy;
    accept    = seeded && advance && !bus.flush && !seed_load;
    xfer      = vld_p[STAGES-1] && bus.out_ready;
    stage_en  = {STAGES{seeded && advance}};
  end

  assign bus.seed_ready = seed_rdy;
  assign bus.in_ready   = accept;
  assign bus.out_valid  = vld_p[STAGES-1];
  assign rnd_out        = lfsr_p;

  // FSM, valid-token shift chain, PRNG and completed-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNSEEDED;
      vld_p    <= '0;
      lfsr_p   <= '0;
      op_count <= '0;
    end else begin
      case (state)
        UNSEEDED: begin
          if (bus.seed_valid) begin
            state  <= RUN;
            lfsr_p <= seed_fix(bus.seed);
          end
        end
        RUN: begin
          // Global stall: the whole chain moves together or not at all.
          if (bus.flush)
            vld_p <= '0;
          else if (advance)
            vld_p <= {vld_p[STAGES-2:0], accept && bus.in_valid};

          // A reseed wins over stepping; otherwise step on every advance.
          if (seed_load)
            lfsr_p <= seed_fix(bus.seed);
          else if (advance)
            lfsr_p <= lfsr_next(lfsr_p);

          if (xfer)
            op_count <= op_count + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_sbox_seq.sv
// Directed bench for masked_sbox_seq with a scoreboard: every accepted token
// queues the op_count value expected when it leaves the pipeline, and a
// monitor pops and compares on each output transfer.
module tb_masked_sbox_seq;
  localparam int STAGES = 6;
  localparam int RND_W  = 12;
  localparam int LFSR_W = 72;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  masked_sbox_seq_if #(.LFSR_W(LFSR_W)) bus ();

  logic [STAGES-1:0] stage_en;
  logic [LFSR_W-1:0] rnd_out;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  op_count;
  logic              seeded;

  masked_sbox_seq #(
    .STAGES(STAGES), .RND_W(RND_W), .LFSR_W(LFSR_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stage_en  (stage_en),
    .rnd_out   (rnd_out),
    .occupancy (occupancy),
    .op_count  (op_count),
    .seeded    (seeded)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_ops = 0;
  logic [71:0] m_lfsr;
  logic        zero_seen;
  localparam logic [71:0] SEED2 = 72'h5A0123456789ABCDEF;

  function automatic logic [71:0] lfsr_step(input logic [71:0] s);
    return {s[70:0], s[71] ^ s[65] ^ s[24] ^ s[18]};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; the reference LFSR steps when the pipeline should advance.
  task automatic tick(input bit adv);
    @(posedge clk);
    #1;
    if (adv) m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic accept_token();
    exp_q.push_back(exp_ops);
    exp_ops++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_seeded"},     72'(seeded),         72'(0));
    check({tag, "_seed_ready"}, 72'(bus.seed_ready), 72'(1));
    check({tag, "_in_ready"},   72'(bus.in_ready),   72'(0));
    check({tag, "_out_valid"},  72'(bus.out_valid),  72'(0));
    check({tag, "_stage_en"},   72'(stage_en),       72'(0));
    check({tag, "_occupancy"},  72'(occupancy),      72'(0));
    check({tag, "_op_count"},   72'(op_count),       72'(0));
    check({tag, "_rnd_out"},    rnd_out,             72'(0));
  endtask

  // Output monitor: each transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    int e;
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got transfer with op_count=%0d required no transfer", op_count);
      end else begin
        e = exp_q.pop_front();
        check("xfer_op_count", 72'(op_count), 72'(e));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.seed_valid = 1'b0;
    bus.seed       = '0;
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    m_lfsr         = '0;
    zero_seen      = 1'b0;

    #12;
    check_reset_values("rst");
    rst_n = 1'b1;

    // Seed with 1, then idle advances shift it left.
    bus.seed_valid = 1'b1;
    bus.seed       = 72'h1;
    tick(1'b0);
    m_lfsr = 72'h1;
    bus.seed_valid = 1'b0;
    check("seeded_after_load", 72'(seeded), 72'(1));
    check("rnd_seed1", rnd_out, 72'h1);
    #1;
    check("stage_en_idle", 72'(stage_en), 72'h3f);
    tick(1'b1);
    check("rnd_step1", rnd_out, 72'h2);
    tick(1'b1);
    check("rnd_step2", rnd_out, 72'h4);

    // Zero seed is loaded as 1 and never returns to zero.
    bus.seed       = '0;
    bus.seed_valid = 1'b1;
    #1;
    check("seed_ready_idle", 72'(bus.seed_ready), 72'(1));
    check("in_ready_seed_cycle", 72'(bus.in_ready), 72'(0));
    tick(1'b0);
    m_lfsr = 72'h1;
    bus.seed_valid = 1'b0;
    check("rnd_zero_seed", rnd_out, 72'h1);
    repeat (100) begin
      tick(1'b1);
      if (rnd_out == '0) zero_seen = 1'b1;
    end
    check("lfsr_never_zero", 72'(zero_seen), 72'(0));
    check("lfsr_100_steps", rnd_out, m_lfsr);

    // Streaming: 10 tokens back to back with the consumer always ready.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("in_ready_stream", 72'(bus.in_ready), 72'(1));
      accept_token();
      tick(1'b1);
      if (k == 4) check("latency_not_yet", 72'(bus.out_valid), 72'(0));
      if (k == 5) begin
        check("latency_six", 72'(bus.out_valid), 72'(1));
        check("occupancy_steady", 72'(occupancy), 72'(6));
      end
    end
    bus.in_valid = 1'b0;
    repeat (6) tick(1'b1);
    check("op_count_stream", 72'(op_count), 72'(10));
    check("occupancy_drained", 72'(occupancy), 72'(0));
    check("rnd_after_stream", rnd_out, m_lfsr);

    // Fill, then stall for 5 cycles: everything frozen.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (6) begin
      accept_token();
      tick(1'b1);
    end
    check("occupancy_full", 72'(occupancy), 72'(6));
    #1;
    check("in_ready_stall", 72'(bus.in_ready), 72'(0));
    check("stage_en_stall", 72'(stage_en), 72'(0));
    repeat (5) tick(1'b0);
    check("occupancy_frozen", 72'(occupancy), 72'(6));
    check("rnd_frozen", rnd_out, m_lfsr);
    check("op_count_frozen", 72'(op_count), 72'(10));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    #1;
    check("stage_en_resume", 72'(stage_en), 72'h3f);
    repeat (6) tick(1'b1);
    check("op_count_after_stall", 72'(op_count), 72'(16));
    check("occupancy_after_stall", 72'(occupancy), 72'(0));

    // Flush with 4 tokens in flight while a new token is offered.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (4) begin
      accept_token();
      tick(1'b1);
    end
    check("occupancy_before_flush", 72'(occupancy), 72'(4));
    bus.flush = 1'b1;
    #1;
    check("in_ready_flush", 72'(bus.in_ready), 72'(0));
    tick(1'b1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) begin
      void'(exp_q.pop_back());
      exp_ops--;
    end
    check("occupancy_flushed", 72'(occupancy), 72'(0));
    check("op_count_flush", 72'(op_count), 72'(16));
    check("out_valid_flush", 72'(bus.out_valid), 72'(0));
    check("rnd_flush_step", rnd_out, m_lfsr);

    // Reseed request blocked until the pipeline drains.
    bus.in_valid = 1'b1;
    repeat (3) begin
      accept_token();
      tick(1'b1);
    end
    bus.in_valid   = 1'b0;
    bus.seed       = SEED2;
    bus.seed_valid = 1'b1;
    #1;
    check("occupancy_reseed", 72'(occupancy), 72'(3));
    check("seed_ready_busy", 72'(bus.seed_ready), 72'(0));
    tick(1'b1);
    check("rnd_no_load_busy", rnd_out, m_lfsr);
    bus.out_ready = 1'b1;
    repeat (5) tick(1'b1);
    check("occupancy_reseed_drained", 72'(occupancy), 72'(0));
    check("op_count_reseed", 72'(op_count), 72'(19));
    #1;
    check("seed_ready_drained", 72'(bus.seed_ready), 72'(1));
    tick(1'b0);
    m_lfsr = SEED2;
    bus.seed_valid = 1'b0;
    check("rnd_reseeded", rnd_out, SEED2);

    // Asynchronous reset in the middle of a stream.
    bus.in_valid = 1'b1;
    repeat (3) begin
      accept_token();
      tick(1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_ops       = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #10;
    rst_n = 1'b1;
    tick(1'b0);
    check("unseeded_after_reset", 72'(seeded), 72'(0));
    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
